// File: rtl/bus_pkg.sv
// Shared types and widths for the bus master stage.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_t;

endpackage

// File: rtl/bus_watchdog.sv
// WAIT-state cycle counter; flags expiry after LIMIT counted cycles.
module bus_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bus_master_if.sv
// Single-outstanding Wishbone classic bus master for the memory manager.
// Optional WAIT timeout enabled by defining BUS_TIMEOUT_EN.
module bus_master_if
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = BUS_ADDR_W,
  parameter int unsigned DATA_W      = BUS_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_req,
  input  logic                write_req,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [DATA_W-1:0]   wdata_in,
  input  logic [DATA_W/8-1:0] sel_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata_out,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   adr_o,
  output logic [DATA_W-1:0]   dat_o,
  output logic [DATA_W/8-1:0] sel_o,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic                ack_i,
  input  logic                err_i
);

  bus_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [DATA_W/8-1:0] sel_q, sel_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                expired;

`ifdef BUS_TIMEOUT_EN
  bus_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == IDLE),
    .en     (state_q == WAIT),
    .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign expired = 1'b0;
`endif

  assign cyc_o     = (state_q == WAIT);
  assign stb_o     = (state_q == WAIT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RESP);
  assign err       = (state_q == RESP) && err_q;
  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign sel_o     = sel_q;
  assign rdata_out = rdata_q;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (read_req || write_req) begin
          state_d = WAIT;
          adr_d   = addr_in;
          dat_d   = wdata_in;
          sel_d   = sel_in;
          // read wins a simultaneous request
          we_d    = !read_req;
          err_d   = 1'b0;
        end
      end
      WAIT: begin
        if (err_i) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else if (ack_i) begin
          state_d = RESP;
          err_d   = 1'b0;
          if (!we_q)
            rdata_d = dat_i;
        end else if (expired) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
